// File: rtl/switch_debounce.sv
// switch_debounce: synchronises and debounces a 3-bit slide-switch code.
// It feeds the registered 3-to-8 active-low LED decoder. enable is 3'b100
// only while the committed code is settled, so the decoder blanks its LEDs
// while the switches bounce.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit BLANK_ON_SETTLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw_switch,
    input  logic       hold,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       stable,
    output logic       changed
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [2:0]       EN_VALID = 3'b100;
    localparam logic [2:0]       EN_BLANK = 3'b000;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_debounce_cycles
        $error("switch_debounce: DEBOUNCE_CYCLES must be in 2..65535");
    end

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_STABLE = 1'b1
    } state_t;

    // Two-flop synchroniser chain; only r_sync_p2 is used by the FSM.
    logic [2:0]       r_sync_p1;
    logic [2:0]       r_sync_p2;

    // FSM state and debounce bookkeeping.
    state_t           r_state;
    logic [2:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_committed;  // at least one commit since reset

    // Registered outputs.
    logic [2:0]       r_switch;
    logic [2:0]       r_enable;
    logic             r_stable;
    logic             r_changed;

    // Next-state values from the combinational FSM process.
    state_t           w_state_nxt;
    logic [2:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_committed_nxt;
    logic [2:0]       w_switch_nxt;
    logic [2:0]       w_enable_nxt;
    logic             w_stable_nxt;
    logic             w_changed_nxt;

    // Count up towards CNT_LAST and park there; the counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_LAST) ? cnt : (cnt + CNT_ONE);
    endfunction

    // Synchroniser shift; hold freezes it so no sample is lost or skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p1 <= 3'b000;
            r_sync_p2 <= 3'b000;
        end else if (!hold) begin
            r_sync_p1 <= raw_switch;
            r_sync_p2 <= r_sync_p1;
        end
    end

    // Next-state and output decode; hold leaves everything as is and drops changed.
    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_cnt_nxt       = r_cnt;
        w_committed_nxt = r_committed;
        w_switch_nxt    = r_switch;
        w_enable_nxt    = r_enable;
        w_stable_nxt    = r_stable;
        w_changed_nxt   = 1'b0;

        if (!hold) begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_sync_p2 != r_cand) begin
                        // New candidate: restart the run of identical samples.
                        w_cand_nxt = r_sync_p2;
                        w_cnt_nxt  = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        // Candidate held long enough: commit it.
                        w_switch_nxt    = r_cand;
                        w_enable_nxt    = EN_VALID;
                        w_stable_nxt    = 1'b1;
                        w_state_nxt     = ST_STABLE;
                        w_committed_nxt = 1'b1;
                        w_changed_nxt   = (r_cand != r_switch) || !r_committed;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end

                ST_STABLE: begin
                    if (r_sync_p2 != r_switch) begin
                        // Input moved away from the committed code: start settling.
                        w_cand_nxt   = r_sync_p2;
                        w_cnt_nxt    = CNT_ZERO;
                        w_stable_nxt = 1'b0;
                        w_state_nxt  = ST_SETTLE;
                        if (BLANK_ON_SETTLE) begin
                            w_enable_nxt = EN_BLANK;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_SETTLE;
                end
            endcase
        end
    end

    // FSM, debounce and output registers; reset is asynchronous and complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SETTLE;
            r_cand      <= 3'b000;
            r_cnt       <= CNT_ZERO;
            r_committed <= 1'b0;
            r_switch    <= 3'b000;
            r_enable    <= EN_BLANK;
            r_stable    <= 1'b0;
            r_changed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_committed <= w_committed_nxt;
            r_switch    <= w_switch_nxt;
            r_enable    <= w_enable_nxt;
            r_stable    <= w_stable_nxt;
            r_changed   <= w_changed_nxt;
        end
    end

    assign switch  = r_switch;
    assign enable  = r_enable;
    assign stable  = r_stable;
    assign changed = r_changed;

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the registered 3-to-8 active-low LED decoder.
- Takes raw, asynchronous 3-bit slide-switch inputs, synchronises and debounces them, then drives the decoder's switch[2:0] and enable[2:0] inputs.
- Drives enable = 3'b100 only when the switch code is settled. The decoder therefore blanks all LEDs (0xff) while the inputs bounce.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a new code. Legal values are 2 to 65535.
- BLANK_ON_SETTLE, 1: 1 = drive enable to 3'b000 while a new code is settling. 0 = keep 3'b100 and the previous code while settling.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- raw_switch  input  3  raw asynchronous switch levels
- hold  input  1  synchronous freeze; 1 = no state or output update this cycle
- switch  output  3  debounced switch code, to decoder switch input
- enable  output  3  3'b100 = code valid; 3'b000 = blank; no other values driven
- stable  output  1  1 while the FSM is in STABLE
- changed  output  1  one-cycle pulse when a committed code differs from the previous one, or on the first commit after reset

Behaviour:
- Reset values: sync1 = sync2 = 0, candidate = 0, count = 0, state = SETTLE, switch = 0, enable = 3'b000, stable = 0, changed = 0. Any rst assertion, including mid-settle, returns every register to these values immediately.
- Synchroniser: 2-flop chain (raw_switch -> sync1 -> sync2). The FSM compares only sync2.
- Counter: width clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
- changed defaults to 0 every cycle unless set below.
- hold = 1 freezes sync1, sync2, state, candidate, count, switch, enable and stable, and forces changed = 0. Synchroniser flops are frozen too, so a value seen before hold is not lost or skipped.
- State SETTLE:
  - If sync2 != candidate: candidate <= sync2, count <= 0, stay in SETTLE.
  - Else if count == DEBOUNCE_CYCLES-1: commit.
    - switch <= candidate; enable <= 3'b100; stable <= 1; state <= STABLE.
    - changed <= 1 if candidate != switch, or if this is the first commit since reset.
  - Else: count <= count + 1.
- State STABLE:
  - If sync2 != switch: candidate <= sync2, count <= 0, stable <= 0, state <= SETTLE. enable <= 3'b000 if BLANK_ON_SETTLE = 1, otherwise unchanged.
  - Else: hold all outputs.
- Bounce back to the old code (glitch shorter than DEBOUNCE_CYCLES): SETTLE recommits the same code. changed stays 0; switch is unchanged.
- Latency: raw change sampled into sync1 at edge E gives the commit (switch/enable/changed update) at edge E+2+DEBOUNCE_CYCLES, provided raw is held constant.
- Reset release with raw = 0 held: first commit at edge DEBOUNCE_CYCLES after release, with changed = 1 and switch = 0.
- Simultaneous hold = 1 and a commit condition: hold wins and the commit occurs on the first non-hold edge.

Test Plan:
- Reset release, raw_switch = 3'd5 constant, N = 4 → enable = 0 until the commit edge; then switch = 5, enable = 3'b100, stable = 1, changed high for exactly 1 cycle.
- Stable at 5, raw -> 3 held; N = 4; BLANK = 1 → stable drops and enable = 0 two edges after sampling. Then switch = 3, enable = 3'b100, changed = 1 at sample edge + 6.
- Stable at 3, raw pulses to 6 for 2 cycles and returns to 3 (N = 4) → switch stays 3 throughout, changed never asserts. enable blanks transiently only when BLANK = 1; with BLANK = 0 enable stays 3'b100.
- Settling 3 -> 7, assert hold for 5 cycles mid-count → count, enable and switch frozen during hold. Commit arrives exactly 5 cycles later than without hold; switch = 7.
- rst pulse mid-settle (asynchronous, between clock edges) → outputs return to reset values immediately. Re-debounce completes from count 0 after release.
- raw toggling every cycle for 20 cycles → no commit and enable = 0 throughout. Once raw is held at 2, commit occurs DEBOUNCE_CYCLES+2 edges later with switch = 2.
